// File: rtl/cache_pkg.sv
// Shared definitions for the L1 caches: FSM states, transfer size codes,
// uncached segment prefix and the byte-enable to transfer-size decoder.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REFILL,
    S_WRITE,
    S_UNC_RD,
    S_DONE
  } cache_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // kseg1 is addr[31:29] == 3'b101 and bypasses the cache
  localparam logic [2:0] KSEG1 = 3'b101;

  typedef struct packed {
    logic       illegal;
    logic [1:0] size;
  } size_dec_t;

  // Byte enables to bus size; wen == 0 is a word read
  function automatic size_dec_t wen_to_size(input logic [3:0] wen);
    size_dec_t d;
    d.illegal = 1'b0;
    d.size    = SZ_WORD;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: d.size = SZ_BYTE;
      4'b0011, 4'b1100:                   d.size = SZ_HALF;
      4'b0000, 4'b1111:                   d.size = SZ_WORD;
      default:                            d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cache_line_ram.sv
// Direct-mapped line storage: valid bits, tag array and word data array
// with a byte-write port, asynchronous read and a clear-all of the valids.
module cache_line_ram #(
  parameter  int unsigned SETS       = 64,
  parameter  int unsigned LINE_WORDS = 4,
  parameter  int unsigned TAG_W      = 22,
  localparam int unsigned IDX_W      = $clog2(SETS),
  localparam int unsigned WORD_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear_all,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WORD_W-1:0] rd_word,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [3:0]        wr_be,
  input  logic [31:0]       wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  tag_data
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS*LINE_WORDS];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_word}];

  // Valid bits: clear-all wins over a same-cycle line install
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (tag_we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Data bytes and tags need no reset; they are guarded by valid
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) data_mem[{wr_idx, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (tag_we) tag_mem[wr_idx] <= tag_data;
  end

endmodule

// File: rtl/data_cache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache between the
// core's SRAM-style data port and the arbitrater's data channel.
module data_cache_wt
  import cache_pkg::*;
#(
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stall,
  input  logic        cache_inv,
  output logic        data_cache_req,
  output logic [31:0] data_cache_addr,
  output logic        data_cache_wr,
  output logic [1:0]  data_cache_size,
  output logic [31:0] data_cache_wdata,
  input  logic [31:0] data_cache_rdata,
  input  logic        data_cache_dok
);

  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = WORD_W + 2;
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;

  cache_state_e state, next_state;
  logic         inv_pending;
  logic [3:0]   be_q;
  logic [31:0]  done_data;

  size_dec_t   dec;
  logic        is_write, legal, xfer_done, last_beat;
  logic        lk_unc, lk_hit, read_hit;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  lk_idx;
  logic [WORD_W-1:0] lk_word;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              ram_we, tag_we, clear_all;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;

  assign dec       = wen_to_size(data_sram_wen);
  assign is_write  = |data_sram_wen;
  assign legal     = !dec.illegal;
  assign xfer_done = data_cache_req && data_cache_dok;
  assign last_beat = data_cache_addr[OFF_W-1:2] == WORD_W'(LINE_WORDS - 1);

  // Look up the core address in IDLE and the in-flight transfer otherwise,
  // so a write hit is judged on the registered address at dok time.
  always_comb begin
    if (state == S_IDLE) begin
      lk_tag  = data_sram_addr[31:OFF_W+IDX_W];
      lk_idx  = data_sram_addr[OFF_W+IDX_W-1:OFF_W];
      lk_word = data_sram_addr[OFF_W-1:2];
      lk_unc  = data_sram_addr[31:29] == KSEG1;
    end else begin
      lk_tag  = data_cache_addr[31:OFF_W+IDX_W];
      lk_idx  = data_cache_addr[OFF_W+IDX_W-1:OFF_W];
      lk_word = data_cache_addr[OFF_W-1:2];
      lk_unc  = data_cache_addr[31:29] == KSEG1;
    end
  end

  assign lk_hit   = rd_valid && (rd_tag == lk_tag) && !lk_unc;
  assign read_hit = data_sram_en && legal && !is_write && lk_hit;

  cache_line_ram #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_ram (
    .clk       (clk),
    .resetn    (resetn),
    .clear_all (clear_all),
    .rd_idx    (lk_idx),
    .rd_word   (lk_word),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (ram_we),
    .wr_idx    (data_cache_addr[OFF_W+IDX_W-1:OFF_W]),
    .wr_word   (data_cache_addr[OFF_W-1:2]),
    .wr_be     (ram_be),
    .wr_data   (ram_wdata),
    .tag_we    (tag_we),
    .tag_data  (data_cache_addr[31:OFF_W+IDX_W])
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (data_sram_en && legal) begin
          if (is_write)    next_state = S_WRITE;
          else if (lk_unc) next_state = S_UNC_RD;
          else if (!lk_hit) next_state = S_REFILL;
        end
      end
      S_REFILL: if (xfer_done && last_beat) next_state = S_IDLE;
      S_WRITE,
      S_UNC_RD: if (xfer_done) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Core-side outputs and line storage controls
  always_comb begin
    stall           = 1'b0;
    data_sram_rdata = '0;
    ram_we          = 1'b0;
    ram_be          = '0;
    ram_wdata       = '0;
    tag_we          = 1'b0;
    case (state)
      S_IDLE: begin
        stall           = data_sram_en && legal && !read_hit;
        data_sram_rdata = read_hit ? rd_data : '0;
      end
      S_REFILL: begin
        stall     = 1'b1;
        ram_we    = xfer_done;
        ram_be    = '1;
        ram_wdata = data_cache_rdata;
        tag_we    = xfer_done && last_beat;
      end
      S_WRITE: begin
        stall     = 1'b1;
        ram_we    = xfer_done && lk_hit;
        ram_be    = be_q;
        ram_wdata = data_cache_wdata;
      end
      S_UNC_RD: stall = 1'b1;
      S_DONE:   data_sram_rdata = done_data;
      default: ;
    endcase
    // A deferred invalidate lands on the same edge that enters IDLE, so the
    // first IDLE cycle already sees every line invalid.
    if (state == S_IDLE) clear_all = cache_inv;
    else                 clear_all = (next_state == S_IDLE) && (cache_inv || inv_pending);
  end

  // Bus request registers, refill beat stepping and result capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_cache_req   <= 1'b0;
      data_cache_addr  <= '0;
      data_cache_wr    <= 1'b0;
      data_cache_size  <= SZ_WORD;
      data_cache_wdata <= '0;
      be_q             <= '0;
      done_data        <= '0;
      inv_pending      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (next_state == S_REFILL) begin
            data_cache_req  <= 1'b1;
            data_cache_addr <= {data_sram_addr[31:OFF_W], OFF_W'(0)};
            data_cache_wr   <= 1'b0;
            data_cache_size <= SZ_WORD;
          end else if (next_state == S_WRITE) begin
            data_cache_req   <= 1'b1;
            data_cache_addr  <= data_sram_addr;
            data_cache_wr    <= 1'b1;
            data_cache_size  <= dec.size;
            data_cache_wdata <= data_sram_wdata;
            be_q             <= data_sram_wen;
          end else if (next_state == S_UNC_RD) begin
            data_cache_req  <= 1'b1;
            data_cache_addr <= {data_sram_addr[31:2], 2'b00};
            data_cache_wr   <= 1'b0;
            data_cache_size <= SZ_WORD;
          end
        end
        S_REFILL: begin
          if (xfer_done) begin
            if (last_beat) data_cache_req <= 1'b0;
            else data_cache_addr[OFF_W-1:2] <= data_cache_addr[OFF_W-1:2] + WORD_W'(1);
          end
        end
        S_WRITE: begin
          if (xfer_done) begin
            data_cache_req <= 1'b0;
            done_data      <= '0;
          end
        end
        S_UNC_RD: begin
          if (xfer_done) begin
            data_cache_req <= 1'b0;
            done_data      <= data_cache_rdata;
          end
        end
        default: ;
      endcase
      if (state == S_IDLE || next_state == S_IDLE) inv_pending <= 1'b0;
      else if (cache_inv)                          inv_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_cache_wt.sv
// Directed bench for data_cache_wt with a two-cycle-latency memory responder.
module tb_data_cache_wt;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        cache_inv = 1'b0;
  logic        req;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic [31:0] dok_rdata = '0;
  logic        dok = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [29:0]];
  logic [31:0] lg_addr[$];
  logic        lg_wr[$];
  logic [1:0]  lg_size[$];
  logic [31:0] lg_wdata[$];

  data_cache_wt #(.SETS(64), .LINE_WORDS(4)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_en     (en),
    .data_sram_wen    (wen),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata),
    .data_sram_rdata  (rdata),
    .stall            (stall),
    .cache_inv        (cache_inv),
    .data_cache_req   (req),
    .data_cache_addr  (req_addr),
    .data_cache_wr    (req_wr),
    .data_cache_size  (req_size),
    .data_cache_wdata (req_wdata),
    .data_cache_rdata (dok_rdata),
    .data_cache_dok   (dok)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {16'hC0DE, a[15:2], 2'b00};
  endfunction

  // Memory side: dok two cycles after req is seen, for one cycle
  initial begin
    int wait_cnt;
    logic [31:0] w;
    logic [3:0] be;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        dok = 1'b0; wait_cnt = 0;
      end else if (dok) begin
        dok = 1'b0; dok_rdata = '0;
      end else if (req) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          wait_cnt = 0;
          dok = 1'b1;
          lg_addr.push_back(req_addr); lg_wr.push_back(req_wr);
          lg_size.push_back(req_size); lg_wdata.push_back(req_wdata);
          if (req_wr) begin
            case (req_size)
              2'b00:   be = 4'b0001 << req_addr[1:0];
              2'b01:   be = req_addr[1] ? 4'b1100 : 4'b0011;
              default: be = 4'b1111;
            endcase
            w = mem_read(req_addr);
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
            mem[req_addr[31:2]] = w;
          end else begin
            dok_rdata = mem_read(req_addr);
          end
        end
      end
    end
  end

  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                        output logic [31:0] rd, output int stalls, output bit ok);
    @(negedge clk);
    en = 1'b1; addr = a; wen = w; wdata = d;
    stalls = 0; ok = 1'b0; rd = 'x;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!stall) begin rd = rdata; ok = 1'b1; break; end
      stalls++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    en = 1'b0; wen = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
    checks++; if (req_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", req_wr); end
    checks++; if (req_size !== 2'b10) begin errors++; $display("FAIL reset_size: got %b expected 10", req_size); end
    checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", req_addr); end
    checks++; if (req_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 00000000", req_wdata); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_miss();
    logic [31:0] rd; int st; bit ok; int n0;
    n0 = lg_addr.size();
    access(32'h0000_1004, 4'b0000, '0, rd, st, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL miss_timeout: got %b expected 1", ok); end
    checks++; if (rd !== 32'hC0DE_1004) begin errors++; $display("FAIL miss_rdata: got %h expected C0DE1004", rd); end
    checks++; if (!(st > 0)) begin errors++; $display("FAIL miss_stalled: got %0d stall cycles expected >0", st); end
    checks++; if (lg_addr.size() - n0 !== 4) begin errors++; $display("FAIL miss_beats: got %0d expected 4", lg_addr.size() - n0); end
    if (lg_addr.size() - n0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (lg_addr[n0+k] !== 32'h1000 + 32'(4*k) || lg_wr[n0+k] !== 1'b0 || lg_size[n0+k] !== 2'b10) begin
          errors++; $display("FAIL miss_beat%0d: got addr %h wr %b size %b expected addr %h wr 0 size 10",
                             k, lg_addr[n0+k], lg_wr[n0+k], lg_size[n0+k], 32'h1000 + 32'(4*k));
        end
      end
    end
    n0 = lg_addr.size();
    access(32'h0000_1008, 4'b0000, '0, rd, st, ok);
    checks++; if (st !== 0) begin errors++; $display("FAIL hit_stall: got %0d expected 0", st); end
    checks++; if (rd !== 32'hC0DE_1008) begin errors++; $display("FAIL hit_rdata: got %h expected C0DE1008", rd); end
    checks++; if (lg_addr.size() !== n0) begin errors++; $display("FAIL hit_no_xfer: got %0d expected %0d", lg_addr.size(), n0); end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; int st; bit ok; int n0;
    n0 = lg_addr.size();
    access(32'h0000_1004, 4'b0010, 32'h0000_AB00, rd, st, ok);
    checks++; if (ok !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL wr_done_rdata: got %h ok %b expected 00000000 ok 1", rd, ok); end
    checks++; if (lg_addr.size() - n0 !== 1) begin errors++; $display("FAIL wr_xfers: got %0d expected 1", lg_addr.size() - n0); end
    if (lg_addr.size() - n0 == 1) begin
      checks++;
      if (lg_addr[n0] !== 32'h1004 || lg_wr[n0] !== 1'b1 || lg_size[n0] !== 2'b00 || lg_wdata[n0] !== 32'h0000_AB00) begin
        errors++; $display("FAIL wr_req: got addr %h wr %b size %b wdata %h expected 00001004 1 00 0000ab00",
                           lg_addr[n0], lg_wr[n0], lg_size[n0], lg_wdata[n0]);
      end
    end
    n0 = lg_addr.size();
    access(32'h0000_1004, 4'b0000, '0, rd, st, ok);
    checks++; if (rd !== 32'hC0DE_AB04) begin errors++; $display("FAIL wr_merge: got %h expected C0DEAB04", rd); end
    checks++; if (st !== 0 || lg_addr.size() !== n0) begin errors++; $display("FAIL wr_no_refill: got %0d stalls %0d xfers expected 0 0", st, lg_addr.size() - n0); end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd; int st; bit ok; int n0;
    n0 = lg_addr.size();
    access(32'h0000_2000, 4'b1111, 32'h1234_5678, rd, st, ok);
    checks++; if (lg_addr.size() - n0 !== 1) begin errors++; $display("FAIL wmiss_xfers: got %0d expected 1", lg_addr.size() - n0); end
    if (lg_addr.size() - n0 == 1) begin
      checks++; if (lg_wr[n0] !== 1'b1 || lg_size[n0] !== 2'b10) begin errors++; $display("FAIL wmiss_req: got wr %b size %b expected 1 10", lg_wr[n0], lg_size[n0]); end
    end
    n0 = lg_addr.size();
    access(32'h0000_2000, 4'b0000, '0, rd, st, ok);
    checks++; if (lg_addr.size() - n0 !== 4) begin errors++; $display("FAIL wmiss_no_alloc: got %0d refill beats expected 4", lg_addr.size() - n0); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL wmiss_rdata: got %h expected 12345678", rd); end
  endtask

  task automatic test_uncached();
    logic [31:0] rd; int st; bit ok; int n0;
    for (int r = 0; r < 2; r++) begin
      n0 = lg_addr.size();
      access(32'hA000_0010, 4'b0000, '0, rd, st, ok);
      checks++; if (lg_addr.size() - n0 !== 1) begin errors++; $display("FAIL unc%0d_xfers: got %0d expected 1", r, lg_addr.size() - n0); end
      else begin
        checks++; if (lg_addr[n0] !== 32'hA000_0010 || lg_wr[n0] !== 1'b0) begin errors++; $display("FAIL unc%0d_req: got addr %h wr %b expected a0000010 0", r, lg_addr[n0], lg_wr[n0]); end
      end
      checks++; if (rd !== 32'hC0DE_0010) begin errors++; $display("FAIL unc%0d_rdata: got %h expected C0DE0010", r, rd); end
    end
  endtask

  task automatic test_inv_during_refill();
    logic [31:0] rd; int st; bit ok; int n0; bit seen;
    n0 = lg_addr.size(); seen = 1'b0;
    fork
      access(32'h0000_3040, 4'b0000, '0, rd, st, ok);
      begin
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk);
          if (lg_addr.size() >= n0 + 1) seen = 1'b1;
        end
        if (seen) begin
          @(negedge clk); cache_inv = 1'b1;
          @(negedge clk); cache_inv = 1'b0;
        end
      end
    join
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL inv_beat_wait: got %b expected 1", seen); end
    checks++; if (lg_addr.size() - n0 !== 8) begin errors++; $display("FAIL inv_refetch: got %0d beats expected 8", lg_addr.size() - n0); end
    else begin
      checks++; if (lg_addr[n0+4] !== 32'h3040) begin errors++; $display("FAIL inv_refetch_start: got %h expected 00003040", lg_addr[n0+4]); end
    end
    checks++; if (rd !== 32'hC0DE_3040) begin errors++; $display("FAIL inv_rdata: got %h expected C0DE3040", rd); end
    n0 = lg_addr.size();
    access(32'h0000_2004, 4'b0000, '0, rd, st, ok);
    checks++; if (lg_addr.size() - n0 !== 4) begin errors++; $display("FAIL inv_other_line: got %0d beats expected 4", lg_addr.size() - n0); end
    checks++; if (rd !== 32'hC0DE_2004) begin errors++; $display("FAIL inv_other_rdata: got %h expected C0DE2004", rd); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd; int st; bit ok; int n0; bit seen;
    n0 = lg_addr.size(); seen = 1'b0;
    @(negedge clk);
    en = 1'b1; addr = 32'h0000_4000; wen = '0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (lg_addr.size() >= n0 + 2) seen = 1'b1;
    end
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_beat_wait: got %b expected 1", seen); end
    checks++; if (req !== 1'b0 || req_addr !== 32'h0) begin errors++; $display("FAIL rst_req: got req %b addr %h expected 0 00000000", req, req_addr); end
    @(negedge clk); en = 1'b0;
    @(negedge clk); resetn = 1'b1;
    checks++; if (lg_addr.size() - n0 !== 2) begin errors++; $display("FAIL rst_partial: got %0d beats expected 2", lg_addr.size() - n0); end
    n0 = lg_addr.size();
    access(32'h0000_4000, 4'b0000, '0, rd, st, ok);
    checks++; if (lg_addr.size() - n0 !== 4) begin errors++; $display("FAIL rst_refill: got %0d beats expected 4", lg_addr.size() - n0); end
    else begin
      checks++; if (lg_addr[n0] !== 32'h4000) begin errors++; $display("FAIL rst_refill_word0: got %h expected 00004000", lg_addr[n0]); end
    end
    checks++; if (rd !== 32'hC0DE_4000) begin errors++; $display("FAIL rst_rdata: got %h expected C0DE4000", rd); end
    n0 = lg_addr.size();
    access(32'h0000_3040, 4'b0000, '0, rd, st, ok);
    checks++; if (lg_addr.size() - n0 !== 4) begin errors++; $display("FAIL rst_all_invalid: got %0d beats expected 4", lg_addr.size() - n0); end
  endtask

  task automatic test_illegal_wen();
    logic [31:0] rd; int st; bit ok; int n0;
    n0 = lg_addr.size();
    access(32'h0000_1000, 4'b0101, 32'hFFFF_FFFF, rd, st, ok);
    checks++; if (st !== 0) begin errors++; $display("FAIL illegal_stall: got %0d expected 0", st); end
    repeat (4) @(negedge clk);
    checks++; if (lg_addr.size() !== n0 || req !== 1'b0) begin errors++; $display("FAIL illegal_req: got %0d xfers req %b expected 0 0", lg_addr.size() - n0, req); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_write_miss();
    test_uncached();
    test_inv_during_refill();
    test_reset_mid_refill();
    test_illegal_wen();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
